// File: rtl/video_cfg_if.sv
// Configuration bundle between the user_io status decode and the video config sequencer:
// requested values flow in and applied values flow out to mist_video.
interface video_cfg_if;
    logic [1:0] scanlines_in;
    logic [1:0] rotate_in;
    logic       blend_in;
    logic       sd_disable_in;
    logic       ypbpr_in;
    logic       no_csync_in;

    logic [1:0] scanlines;
    logic [1:0] rotate;
    logic       blend;
    logic       scandoubler_disable;
    logic       ypbpr;
    logic       no_csync;

    modport master (
        output scanlines_in, rotate_in, blend_in, sd_disable_in, ypbpr_in, no_csync_in,
        input  scanlines, rotate, blend, scandoubler_disable, ypbpr, no_csync
    );

    modport slave (
        input  scanlines_in, rotate_in, blend_in, sd_disable_in, ypbpr_in, no_csync_in,
        output scanlines, rotate, blend, scandoubler_disable, ypbpr, no_csync
    );
endinterface

// File: rtl/video_cfg_sequencer.sv
// Latches video pipeline configuration only at frame boundaries and mutes video for a few
// frames after sync-affecting changes; a watchdog supplies boundaries when VBlank stops.
module video_cfg_sequencer #(
    parameter int MUTE_FRAMES = 2,
    parameter int TO_WIDTH    = 22
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         VBlank,
    video_cfg_if.slave   cfg,
    output logic         mute,
    output logic         cfg_pending,
    output logic         vs_lost
);

    typedef struct packed {
        logic [1:0] scanlines;
        logic [1:0] rotate;
        logic       blend;
        logic       sd_disable;
        logic       ypbpr;
        logic       no_csync;
    } cfg_t;

    typedef enum logic {IDLE, MUTE} state_t;

    localparam logic [3:0] MF = 4'(MUTE_FRAMES);

    cfg_t                cfg_in, cfg_q, applied;
    state_t              state;
    logic [3:0]          mcnt;
    logic                force_major;
    logic                vb_d;
    logic [TO_WIDTH-1:0] wd;
    logic                real_fb, syn_fb, fb;
    logic                real_q, syn_q, fb_q;
    logic                major_diff;

    assign cfg_in = '{scanlines:  cfg.scanlines_in,
                      rotate:     cfg.rotate_in,
                      blend:      cfg.blend_in,
                      sd_disable: cfg.sd_disable_in,
                      ypbpr:      cfg.ypbpr_in,
                      no_csync:   cfg.no_csync_in};

    assign cfg.scanlines           = applied.scanlines;
    assign cfg.rotate              = applied.rotate;
    assign cfg.blend               = applied.blend;
    assign cfg.scandoubler_disable = applied.sd_disable;
    assign cfg.ypbpr               = applied.ypbpr;
    assign cfg.no_csync            = applied.no_csync;

    assign real_fb = VBlank & ~vb_d;
    assign syn_fb  = &wd;
    assign fb      = real_fb | syn_fb;
    // Boundary is acted on one cycle later so outputs move on the second edge after VBlank rises
    assign fb_q    = real_q | syn_q;

    assign major_diff = force_major ||
        ({cfg_q.sd_disable, cfg_q.ypbpr, cfg_q.no_csync} !=
         {applied.sd_disable, applied.ypbpr, applied.no_csync});

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cfg_q       <= '0;
            applied     <= '0;
            cfg_pending <= 1'b0;
            vb_d        <= 1'b1;
            wd          <= '0;
            real_q      <= 1'b0;
            syn_q       <= 1'b0;
            vs_lost     <= 1'b0;
            mute        <= 1'b1;
            state       <= MUTE;
            mcnt        <= MF;
            force_major <= 1'b1;
        end else begin
            cfg_q       <= cfg_in;
            cfg_pending <= (cfg_q != applied);
            vb_d        <= VBlank;
            wd          <= fb ? '0 : wd + 1'b1;
            real_q      <= real_fb;
            syn_q       <= syn_fb;

            if (real_q)     vs_lost <= 1'b0;
            else if (syn_q) vs_lost <= 1'b1;

            if (fb_q) begin
                applied <= cfg_q;
                case (state)
                    IDLE: begin
                        if (major_diff) begin
                            mute  <= 1'b1;
                            mcnt  <= MF;
                            state <= MUTE;
                        end
                    end
                    MUTE: begin
                        if (major_diff) begin
                            mcnt        <= MF;
                            force_major <= 1'b0;
                        end else begin
                            mcnt <= mcnt - 4'd1;
                            if (mcnt == 4'd1) begin
                                mute  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Directed bench: hand-computed frame table plus sequences for latency, reset and watchdog.
module tb_video_cfg_sequencer;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic VBlank  = 1'b0;
    logic mute, cfg_pending, vs_lost;

    video_cfg_if cif();

    video_cfg_sequencer #(.MUTE_FRAMES(2), .TO_WIDTH(8)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .VBlank      (VBlank),
        .cfg         (cif),
        .mute        (mute),
        .cfg_pending (cfg_pending),
        .vs_lost     (vs_lost)
    );

    always #5 clk_sys = ~clk_sys;

    // bit order: scanlines[7:6] rotate[5:4] blend[3] sd_disable[2] ypbpr[1] no_csync[0]
    typedef struct packed {
        logic [1:0] sl;
        logic [1:0] rot;
        logic       bl;
        logic       sd;
        logic       yp;
        logic       nc;
    } cfg_t;

    typedef struct {
        cfg_t in;
        logic pend;
        cfg_t out;
        logic mute;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic cfg_t get_out();
        return '{sl: cif.scanlines, rot: cif.rotate, bl: cif.blend,
                 sd: cif.scandoubler_disable, yp: cif.ypbpr, nc: cif.no_csync};
    endfunction

    task automatic set_in(input cfg_t c);
        cif.scanlines_in  = c.sl;
        cif.rotate_in     = c.rot;
        cif.blend_in      = c.bl;
        cif.sd_disable_in = c.sd;
        cif.ypbpr_in      = c.yp;
        cif.no_csync_in   = c.nc;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic boundary();
        VBlank = 1'b1;
        repeat (10) tick();
        VBlank = 1'b0;
        repeat (85) tick();
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        @(negedge clk_sys);
        set_in(v.in);
        tick();
        tick();
        chk($sformatf("v%0d_pend_early", idx), cfg_pending, v.pend);
        repeat (3) tick();
        boundary();
        chk($sformatf("v%0d_out", idx), get_out(), v.out);
        chk($sformatf("v%0d_mute", idx), mute, v.mute);
        chk($sformatf("v%0d_pend_late", idx), cfg_pending, 1'b0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{in: 8'h44, pend: 1'b0, out: 8'h44, mute: 1'b1};
        vecs[1]  = '{in: 8'h44, pend: 1'b0, out: 8'h44, mute: 1'b0};
        vecs[2]  = '{in: 8'h74, pend: 1'b1, out: 8'h74, mute: 1'b0};
        vecs[3]  = '{in: 8'hBC, pend: 1'b1, out: 8'hBC, mute: 1'b0};
        vecs[4]  = '{in: 8'hBE, pend: 1'b1, out: 8'hBE, mute: 1'b1};
        vecs[5]  = '{in: 8'hBE, pend: 1'b0, out: 8'hBE, mute: 1'b1};
        vecs[6]  = '{in: 8'hBF, pend: 1'b1, out: 8'hBF, mute: 1'b1};
        vecs[7]  = '{in: 8'hBF, pend: 1'b0, out: 8'hBF, mute: 1'b1};
        vecs[8]  = '{in: 8'hBF, pend: 1'b0, out: 8'hBF, mute: 1'b0};
        vecs[9]  = '{in: 8'h39, pend: 1'b1, out: 8'h39, mute: 1'b1};
        vecs[10] = '{in: 8'h39, pend: 1'b0, out: 8'h39, mute: 1'b1};
        vecs[11] = '{in: 8'h39, pend: 1'b0, out: 8'h39, mute: 1'b0};

        set_in(8'h00);
        repeat (3) tick();
        chk("reset_out", get_out(), 8'h00);
        chk("reset_mute", mute, 1'b1);
        chk("reset_pend", cfg_pending, 1'b0);
        chk("reset_vslost", vs_lost, 1'b0);

        // first boundary after reset: forced major apply, two-edge latency
        @(negedge clk_sys);
        reset = 1'b0;
        set_in(8'h44);
        repeat (20) tick();
        chk("pre_fb_out", get_out(), 8'h00);
        chk("pre_fb_mute", mute, 1'b1);
        chk("pre_fb_pend", cfg_pending, 1'b1);
        VBlank = 1'b1;
        tick();
        chk("lat_edge1_out", get_out(), 8'h00);
        tick();
        chk("lat_edge2_out", get_out(), 8'h44);
        chk("lat_edge2_mute", mute, 1'b1);
        repeat (8) tick();
        VBlank = 1'b0;
        repeat (85) tick();

        for (int i = 0; i < 12; i++) run_frame(i, vecs[i]);

        // ypbpr request toggles away and back inside one frame
        @(negedge clk_sys);
        set_in(8'h3B);
        repeat (3) tick();
        chk("tog_pend_hi", cfg_pending, 1'b1);
        set_in(8'h39);
        repeat (3) tick();
        chk("tog_pend_lo", cfg_pending, 1'b0);
        boundary();
        chk("tog_out", get_out(), 8'h39);
        chk("tog_mute", mute, 1'b0);
        chk("tog_pend_end", cfg_pending, 1'b0);

        // reset while muted with a change pending; VBlank high across release
        run_frame(12, '{in: 8'h3B, pend: 1'b1, out: 8'h3B, mute: 1'b1});
        @(negedge clk_sys);
        set_in(8'h1B);
        repeat (5) tick();
        chk("rst_mid_pend", cfg_pending, 1'b1);
        reset  = 1'b1;
        VBlank = 1'b1;
        repeat (3) tick();
        chk("rst_mid_out", get_out(), 8'h00);
        chk("rst_mid_mute", mute, 1'b1);
        chk("rst_mid_pend0", cfg_pending, 1'b0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (5) tick();
        chk("vb_high_at_release_out", get_out(), 8'h00);
        VBlank = 1'b0;
        repeat (10) tick();
        boundary();
        chk("rst_apply_out", get_out(), 8'h1B);
        chk("rst_apply_mute", mute, 1'b1);

        // watchdog: VBlank held low, timeouts drive the boundaries
        @(negedge clk_sys);
        reset = 1'b1;
        set_in(8'h08);
        repeat (3) tick();
        @(negedge clk_sys);
        reset = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (k == 256) begin
                chk("wd_before_out", get_out(), 8'h00);
                chk("wd_before_vslost", vs_lost, 1'b0);
            end
            if (k == 257) begin
                chk("wd_first_out", get_out(), 8'h08);
                chk("wd_first_vslost", vs_lost, 1'b1);
                chk("wd_first_mute", mute, 1'b1);
            end
            if (k == 768) chk("wd_mute_held", mute, 1'b1);
            if (k == 769) begin
                chk("wd_mute_clear", mute, 1'b0);
                chk("wd_vslost_held", vs_lost, 1'b1);
            end
        end
        VBlank = 1'b1;
        tick();
        chk("real_fb_vslost_e1", vs_lost, 1'b1);
        tick();
        chk("real_fb_vslost_e2", vs_lost, 1'b0);
        chk("real_fb_mute", mute, 1'b0);
        VBlank = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
